// File: rtl/game_pkg.sv
// Shared game definitions: round states, bus widths and default timing constants
// used by the round sequencer, health counter and display blocks.
package game_pkg;

   localparam int unsigned HEALTH_W  = 7;
   localparam int unsigned RATE_W    = 27;
   localparam int unsigned SCORE_W   = 14;
   localparam int unsigned LEVEL_W   = 4;
   localparam int unsigned SCORE_MAX = 9999;

   localparam int unsigned DEF_BASE_RATE = 50_000_000;
   localparam int unsigned DEF_RATE_STEP = 4_000_000;
   localparam int unsigned DEF_MIN_RATE  = 10_000_000;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      PLAY,
      REWARD,
      OVER
   } round_state_t;

endpackage

// File: rtl/rate_sched.sv
// Level-to-drain-rate scheduler: health_rate = max(BASE - level*STEP, MIN), registered.
module rate_sched
   import game_pkg::*;
#(
   parameter int unsigned BASE_RATE = DEF_BASE_RATE,
   parameter int unsigned RATE_STEP = DEF_RATE_STEP,
   parameter int unsigned MIN_RATE  = DEF_MIN_RATE
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               i_clear,
   input  logic [LEVEL_W-1:0] i_level,
   output logic [RATE_W-1:0]  o_rate
);

   localparam logic [27:0] BASE28 = 28'(BASE_RATE);
   localparam logic [27:0] STEP28 = 28'(RATE_STEP);
   localparam logic [27:0] MIN28  = 28'(MIN_RATE);

   logic [27:0]       w_product;
   logic [27:0]       w_diff;
   logic [RATE_W-1:0] w_rate;

   // One spare bit above the rate width: a subtraction that goes below zero
   // wraps with bit 27 set and is caught by the clamp instead of aliasing.
   always_comb begin
      // NOTE: every always_comb output is assigned up front so no path can infer a latch.
      w_rate    = RATE_W'(MIN_RATE);
      w_product = 28'(i_level) * STEP28;
      w_diff    = BASE28 - w_product;
      if (!w_diff[27] && (w_diff >= MIN28)) begin
         w_rate = w_diff[RATE_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         o_rate <= RATE_W'(BASE_RATE);
      end else if (i_clear) begin
         o_rate <= RATE_W'(BASE_RATE);
      end else begin
         o_rate <= w_rate;
      end
   end

endmodule

// File: rtl/round_ctrl.sv
// Game-round sequencer: start/play/reward/over flow, scoring, levelling, and
// the control side (rate, add, restart) of the downstream health counter.
module round_ctrl
   import game_pkg::*;
#(
   parameter int unsigned BASE_RATE  = DEF_BASE_RATE,
   parameter int unsigned RATE_STEP  = DEF_RATE_STEP,
   parameter int unsigned MIN_RATE   = DEF_MIN_RATE,
   parameter int unsigned LEVEL_UP   = 5,
   parameter int unsigned MAX_LEVEL  = 9,
   parameter int unsigned REWARD_HP  = 3,
   parameter int unsigned MAX_HEALTH = 99
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                answer_valid,
   input  logic                answer_correct,
   input  logic [HEALTH_W-1:0] current_health,
   input  logic                no_health,
   output logic [RATE_W-1:0]   health_rate,
   output logic                add_health,
   output logic                health_rst_n,
   output logic [LEVEL_W-1:0]  level,
   output logic [SCORE_W-1:0]  score,
   output logic                playing,
   output logic                game_over
);

   localparam int CNT_W = $clog2(LEVEL_UP + 1);
   localparam int RWD_W = $clog2(REWARD_HP + 1);

   round_state_t       r_state;
   logic [CNT_W-1:0]   r_correct_cnt;
   logic [RWD_W-1:0]   r_reward_cnt;

   logic               w_correct;
   logic [CNT_W-1:0]   w_cnt_inc;
   logic               w_level_up;
   logic [LEVEL_W-1:0] w_level_inc;
   logic [SCORE_W-1:0] w_score_inc;
   logic [HEALTH_W:0]  w_hp_ahead;
   logic               w_hp_room;
   logic               w_rate_clear;

   assign w_correct    = answer_valid & answer_correct;
   assign w_cnt_inc    = r_correct_cnt + 1'b1;
   assign w_level_up   = (w_cnt_inc == CNT_W'(LEVEL_UP));
   assign w_level_inc  = (level >= LEVEL_W'(MAX_LEVEL)) ? level : level + 1'b1;
   assign w_score_inc  = (score >= SCORE_W'(SCORE_MAX)) ? score : score + 1'b1;
   assign w_rate_clear = (r_state == ARM);

   // add_health is registered, so the HP it grants lands one cycle late; count
   // the increment already in flight so the counter never overshoots the cap.
   assign w_hp_ahead = {1'b0, current_health} + {{HEALTH_W{1'b0}}, add_health};
   assign w_hp_room  = (w_hp_ahead < (HEALTH_W + 1)'(MAX_HEALTH));

   rate_sched #(
      .BASE_RATE (BASE_RATE),
      .RATE_STEP (RATE_STEP),
      .MIN_RATE  (MIN_RATE)
   ) u_rate_sched (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_rate_clear),
      .i_level (level),
      .o_rate  (health_rate)
   );

   // Each branch sets the outputs for the state being entered, so every
   // output is a plain flop that matches the registered state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_correct_cnt <= '0;
         r_reward_cnt  <= '0;
         level         <= '0;
         score         <= '0;
         add_health    <= 1'b0;
         health_rst_n  <= 1'b0;
         playing       <= 1'b0;
         game_over     <= 1'b0;
      end else begin
         // NOTE: state and counters use non-blocking assignments so all flops
         // update together from the values seen before this edge.
         case (r_state)
            IDLE: begin
               add_health   <= 1'b0;
               health_rst_n <= 1'b0;
               playing      <= 1'b0;
               game_over    <= 1'b0;
               if (start) begin
                  r_state <= ARM;
               end
            end

            ARM: begin
               r_correct_cnt <= '0;
               r_reward_cnt  <= '0;
               level         <= '0;
               score         <= '0;
               add_health    <= 1'b0;
               health_rst_n  <= 1'b1;
               playing       <= 1'b1;
               game_over     <= 1'b0;
               r_state       <= PLAY;
            end

            PLAY: begin
               add_health <= 1'b0;
               if (no_health) begin
                  playing   <= 1'b0;
                  game_over <= 1'b1;
                  r_state   <= OVER;
               end else if (w_correct) begin
                  score        <= w_score_inc;
                  r_reward_cnt <= RWD_W'(REWARD_HP);
                  if (w_level_up) begin
                     r_correct_cnt <= '0;
                     level         <= w_level_inc;
                  end else begin
                     r_correct_cnt <= w_cnt_inc;
                  end
                  r_state <= REWARD;
               end
            end

            REWARD: begin
               if (no_health) begin
                  add_health   <= 1'b0;
                  r_reward_cnt <= '0;
                  playing      <= 1'b0;
                  game_over    <= 1'b1;
                  r_state      <= OVER;
               end else if (r_reward_cnt != '0) begin
                  add_health   <= w_hp_room;
                  r_reward_cnt <= r_reward_cnt - 1'b1;
               end else begin
                  add_health <= 1'b0;
                  r_state    <= PLAY;
               end
            end

            OVER: begin
               add_health <= 1'b0;
               if (start) begin
                  health_rst_n <= 1'b0;
                  game_over    <= 1'b0;
                  r_state      <= ARM;
               end
            end

            default: begin
               add_health   <= 1'b0;
               health_rst_n <= 1'b0;
               playing      <= 1'b0;
               game_over    <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_round_ctrl.sv
// Directed bench for round_ctrl with a behavioural health counter in the loop;
// a second instance with a steeper rate step exercises the rate floor.
module tb_round_ctrl;
   import game_pkg::*;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                start = 1'b0;
   logic                answer_valid = 1'b0;
   logic                answer_correct = 1'b0;
   logic                no_health = 1'b0;

   logic [RATE_W-1:0]   health_rate;
   logic                add_health;
   logic                health_rst_n;
   logic [LEVEL_W-1:0]  level;
   logic [SCORE_W-1:0]  score;
   logic                playing;
   logic                game_over;

   logic [RATE_W-1:0]   s_health_rate;
   logic                s_add_health;
   logic                s_health_rst_n;
   logic [LEVEL_W-1:0]  s_level;
   logic [SCORE_W-1:0]  s_score;
   logic                s_playing;
   logic                s_game_over;

   logic [HEALTH_W-1:0] hp = '0;
   logic                hp_load = 1'b0;
   logic [HEALTH_W-1:0] hp_load_val = '0;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Minimal health counter: restarts at 20, +1 per add_health cycle, test preload.
   always @(posedge clk) begin
      if (!health_rst_n)      hp <= 7'd20;
      else if (hp_load)       hp <= hp_load_val;
      else if (add_health)    hp <= hp + 7'd1;
   end

   round_ctrl u_dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .answer_valid   (answer_valid),
      .answer_correct (answer_correct),
      .current_health (hp),
      .no_health      (no_health),
      .health_rate    (health_rate),
      .add_health     (add_health),
      .health_rst_n   (health_rst_n),
      .level          (level),
      .score          (score),
      .playing        (playing),
      .game_over      (game_over)
   );

   round_ctrl #(.RATE_STEP(6_000_000)) u_steep (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .answer_valid   (answer_valid),
      .answer_correct (answer_correct),
      .current_health (hp),
      .no_health      (no_health),
      .health_rate    (s_health_rate),
      .add_health     (s_add_health),
      .health_rst_n   (s_health_rst_n),
      .level          (s_level),
      .score          (s_score),
      .playing        (s_playing),
      .game_over      (s_game_over)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Correct answer from PLAY; returns once the reward has finished and PLAY is back.
   task automatic correct_answer;
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      logic [4:0] add_pat;

      // 1: reset, then idle with no start
      repeat (2) tick();
      check("rst_health_rst_n", 32'(health_rst_n), 32'd0);
      check("rst_health_rate", 32'(health_rate), 32'd50_000_000);
      check("rst_add_health", 32'(add_health), 32'd0);
      check("rst_playing", 32'(playing), 32'd0);
      check("rst_game_over", 32'(game_over), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_score", 32'(score), 32'd0);
      #2 reset = 1'b1;
      tick();
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      tick();
      check("idle_ignores_answer", 32'(score), 32'd0);
      check("idle_health_rst_n", 32'(health_rst_n), 32'd0);
      check("idle_playing", 32'(playing), 32'd0);

      // 2: start -> ARM -> PLAY, first correct answer grants 3 HP
      start = 1'b1;
      tick();
      start = 1'b0;
      check("arm_health_rst_n", 32'(health_rst_n), 32'd0);
      check("arm_playing", 32'(playing), 32'd0);
      tick();
      check("play_health_rst_n", 32'(health_rst_n), 32'd1);
      check("play_playing", 32'(playing), 32'd1);
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      check("reward_first_add", 32'(add_health), 32'd0);
      check("reward_score", 32'(score), 32'd1);
      add_pat = 5'b00111;
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("reward_add_%0d", i), 32'(add_health), 32'(add_pat[i]));
      end
      check("hp_after_reward", 32'(hp), 32'd23);
      check("back_in_play", 32'(playing), 32'd1);

      // 3: levelling and rate schedule
      repeat (3) correct_answer();
      check("level_before_5", 32'(level), 32'd0);
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      check("level_at_5", 32'(level), 32'd1);
      check("score_at_5", 32'(score), 32'd5);
      check("rate_lags_level", 32'(health_rate), 32'd50_000_000);
      tick();
      check("rate_level1", 32'(health_rate), 32'd46_000_000);
      repeat (3) tick();
      repeat (10) correct_answer();
      check("level_at_15", 32'(level), 32'd3);
      check("score_at_15", 32'(score), 32'd15);
      check("rate_level3", 32'(health_rate), 32'd38_000_000);
      check("steep_rate_level3", 32'(s_health_rate), 32'd32_000_000);
      repeat (30) correct_answer();
      check("level_at_45", 32'(level), 32'd9);
      check("rate_level9", 32'(health_rate), 32'd14_000_000);
      check("steep_rate_floor", 32'(s_health_rate), 32'd10_000_000);
      check("hp_capped", 32'(hp), 32'd99);
      check("steep_level", 32'(s_level), 32'd9);
      check("steep_score", 32'(s_score), 32'd45);
      check("steep_playing", 32'(s_playing), 32'd1);
      check("steep_game_over", 32'(s_game_over), 32'd0);
      check("steep_add", 32'(s_add_health), 32'd0);
      check("steep_health_rst_n", 32'(s_health_rst_n), 32'd1);
      repeat (5) correct_answer();
      check("level_saturates", 32'(level), 32'd9);
      check("score_at_50", 32'(score), 32'd50);

      // 4: reward near the cap, answer during REWARD dropped
      hp_load_val = 7'd98;
      hp_load     = 1'b1;
      tick();
      hp_load     = 1'b0;
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      check("cap_add_e1", 32'(add_health), 32'd0);
      check("cap_score", 32'(score), 32'd51);
      tick();
      check("cap_add_e2", 32'(add_health), 32'd1);
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      check("cap_add_e3", 32'(add_health), 32'd0);
      tick();
      check("cap_add_e4", 32'(add_health), 32'd0);
      tick();
      check("cap_add_e5", 32'(add_health), 32'd0);
      check("reward_answer_dropped", 32'(score), 32'd51);
      check("cap_hp", 32'(hp), 32'd99);
      correct_answer();
      check("play_after_cap", 32'(score), 32'd52);
      check("hp_stays_capped", 32'(hp), 32'd99);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_play_rst_n", 32'(health_rst_n), 32'd1);
      check("start_in_play_playing", 32'(playing), 32'd1);

      // 5: no_health beats a correct answer; restart clears score/level
      no_health      = 1'b1;
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      no_health      = 1'b0;
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      check("over_game_over", 32'(game_over), 32'd1);
      check("over_playing", 32'(playing), 32'd0);
      check("over_score_unchanged", 32'(score), 32'd52);
      check("over_add", 32'(add_health), 32'd0);
      repeat (3) tick();
      check("over_level_held", 32'(level), 32'd9);
      check("over_score_held", 32'(score), 32'd52);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rearm_health_rst_n", 32'(health_rst_n), 32'd0);
      check("rearm_game_over", 32'(game_over), 32'd0);
      tick();
      check("replay_playing", 32'(playing), 32'd1);
      check("replay_health_rst_n", 32'(health_rst_n), 32'd1);
      check("replay_score", 32'(score), 32'd0);
      check("replay_level", 32'(level), 32'd0);
      check("replay_rate", 32'(health_rate), 32'd50_000_000);
      check("replay_steep_rate", 32'(s_health_rate), 32'd50_000_000);

      // no_health during REWARD
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      tick();
      check("reward2_add", 32'(add_health), 32'd1);
      no_health = 1'b1;
      tick();
      no_health = 1'b0;
      check("reward_over_game_over", 32'(game_over), 32'd1);
      check("reward_over_add", 32'(add_health), 32'd0);
      check("reward_over_score", 32'(score), 32'd1);

      // 6: asynchronous reset in the middle of a reward
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      repeat (5) correct_answer();
      check("pre_reset_level", 32'(level), 32'd1);
      answer_valid   = 1'b1;
      answer_correct = 1'b1;
      tick();
      answer_valid   = 1'b0;
      answer_correct = 1'b0;
      tick();
      check("pre_reset_add", 32'(add_health), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_add", 32'(add_health), 32'd0);
      check("async_score", 32'(score), 32'd0);
      check("async_level", 32'(level), 32'd0);
      check("async_rate", 32'(health_rate), 32'd50_000_000);
      check("async_health_rst_n", 32'(health_rst_n), 32'd0);
      check("async_playing", 32'(playing), 32'd0);
      check("async_game_over", 32'(game_over), 32'd0);
      tick();
      check("reset_held_add", 32'(add_health), 32'd0);
      reset = 1'b1;
      tick();
      check("post_reset_idle_playing", 32'(playing), 32'd0);
      check("post_reset_idle_rst_n", 32'(health_rst_n), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
